pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen.sv | 134 +++++++++++++
 tb/tb_pulse_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen.sv
// Pulse burst generator: emits req_count isolated 1-cycle highs on data_out,
// each separated by max(req_gap,1) low cycles, with lead and tail low cycles.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   burst request handshake
//   req_count, req_gap    pulse count and inter-pulse gap of the request
//   abort                 terminate the burst in progress
//   data_out              registered serial pulse line
//   busy                  burst in progress
//   done, aborted         1-cycle completion strobes (registered)
module pulse_gen #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_count,
  input  logic [GAP_W-1:0] req_gap,
  input  logic             abort,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_HIGH,
    S_GAP,
    S_TAIL
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_rem;
  logic [GAP_W-1:0] r_gap_ld;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_data;
  logic             r_done;
  logic             r_aborted;

  logic             w_accept;
  logic             w_abort_take;
  logic             w_last;
  logic             w_data_nxt;
  logic             w_done_nxt;

  assign req_ready = (r_state == S_IDLE) && !abort;
  assign w_accept  = req_valid && req_ready;
  assign w_last    = (r_rem == CNT_W'(1));

  // TAIL and IDLE are deliberately immune to abort
  assign w_abort_take = abort &&
    ((r_state == S_LEAD) ||
     (r_state == S_HIGH) ||
     (r_state == S_GAP));

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_gap_ld  <= '0;
      r_gap_cnt <= '0;
      r_data    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_data    <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_abort_take;
      if (w_accept) begin
        r_rem    <= req_count;
        r_gap_ld <= (req_gap == '0) ? GAP_W'(1) : req_gap;
      end else if (w_abort_take) begin
        r_rem     <= '0;
        r_gap_cnt <= '0;
      end else if (r_state == S_HIGH) begin
        r_rem <= r_rem - CNT_W'(1);
        if (!w_last)
          r_gap_cnt <= r_gap_ld;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = (req_count == '0) ? S_TAIL : S_LEAD;
      end
      S_LEAD: begin
        w_next = abort ? S_IDLE : S_HIGH;
      end
      S_HIGH: begin
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_TAIL;
        else             w_next = S_GAP;
      end
      S_GAP: begin
        if (abort)
          w_next = S_IDLE;
        else if (r_gap_cnt == GAP_W'(1))
          w_next = S_HIGH;
      end
      S_TAIL: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // outputs are precomputed from the next state so they can be registered
  always_comb begin
    w_data_nxt = (w_next == S_HIGH);
    w_done_nxt = (w_next == S_TAIL);
  end

  assign data_out = r_data;
  assign done     = r_done;
  assign aborted  = r_aborted;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_pulse_gen.sv
// Testbench for pulse_gen: directed vector table, reset/abort sequences,
// and random bursts with a 0-1-0 pattern monitor.
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_count = '0;
  logic [3:0] req_gap = '0;
  logic       abort = 1'b0;
  logic       data_out;
  logic       busy;
  logic       done;
  logic       aborted;

  int n_chk = 0;
  int n_pass = 0;

  pulse_gen #(.CNT_W(8), .GAP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_count (req_count),
    .req_gap   (req_gap),
    .abort     (abort),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    int          gap;
    int          ab_in;
    bit          noise;
    logic [31:0] mask;
    int          done_c;
    int          abt_c;
  } vec_t;

  vec_t v[11];

  logic [2:0] hist = '0;
  bit         mon_en = 1'b0;
  int         hits = 0;
  int         wide = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      hist = {hist[1:0], data_out};
      if (hist == 3'b010) hits++;
      if (hist[1:0] == 2'b11) wide++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic run_vec(input int i);
    int          e;
    logic [31:0] m;
    m = v[i].mask;
    e = (v[i].done_c != 0) ? v[i].done_c + 1 : v[i].abt_c;
    req_valid = 1'b1;
    req_count = 8'(v[i].cnt);
    req_gap   = 4'(v[i].gap);
    abort     = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= e; c++) begin
      if (c > 1) @(posedge clk);
      #1;
      abort     = (c == v[i].ab_in);
      req_valid = v[i].noise && (c < e);
      if (v[i].noise) begin
        req_count = 8'd7;
        req_gap   = 4'd9;
      end
      @(negedge clk);
      chk($sformatf("v%0d c%0d data", i, c), 32'(data_out), 32'(m[c]));
      chk($sformatf("v%0d c%0d done", i, c), 32'(done),
          32'(c == v[i].done_c));
      chk($sformatf("v%0d c%0d aborted", i, c), 32'(aborted),
          32'(c == v[i].abt_c));
      chk($sformatf("v%0d c%0d busy", i, c), 32'(busy), 32'(c < e));
    end
    chk($sformatf("v%0d ready", i), 32'(req_ready), 32'd1);
  endtask

  initial begin
    int sum;
    int ok;
    v[0]  = '{3, 2, 0, 1'b0, 32'h124,   9,  0};
    v[1]  = '{2, 0, 0, 1'b0, 32'h14,    5,  0};
    v[2]  = '{0, 5, 0, 1'b0, 32'h0,     1,  0};
    v[3]  = '{1, 5, 0, 1'b0, 32'h4,     3,  0};
    v[4]  = '{4, 1, 0, 1'b0, 32'h154,   9,  0};
    v[5]  = '{2, 15, 0, 1'b0, 32'h40004, 19, 0};
    v[6]  = '{5, 3, 7, 1'b0, 32'h44,    0,  8};
    v[7]  = '{3, 1, 1, 1'b0, 32'h0,     0,  2};
    v[8]  = '{2, 2, 2, 1'b0, 32'h4,     0,  3};
    v[9]  = '{1, 1, 3, 1'b0, 32'h4,     3,  0};
    v[10] = '{3, 2, 0, 1'b1, 32'h124,   9,  0};

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst data", 32'(data_out), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst aborted", 32'(aborted), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++) run_vec(i);

    // abort in IDLE blocks acceptance only
    abort = 1'b1;
    req_valid = 1'b1;
    req_count = 8'd1;
    #1;
    chk("idle abort ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("idle abort busy", 32'(busy), 32'd0);
    chk("idle abort strobe", 32'(aborted), 32'd0);
    abort = 1'b0;
    req_valid = 1'b0;

    // reset during GAP of count=4 gap=2 burst
    req_valid = 1'b1;
    req_count = 8'd4;
    req_gap   = 4'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid gap busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst busy", 32'(busy), 32'd1);
    chk("async rst data", 32'(data_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst data", 32'(data_out), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst aborted", 32'(aborted), 32'd0);
    rst_n = 1'b1;
    req_valid = 1'b1;
    req_count = 8'd1;
    req_gap   = 4'd1;
    #1;
    chk("post rst ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("post rst busy", 32'(busy), 32'd1);
    chk("post rst strobe", 32'(done | aborted), 32'd0);
    @(negedge clk);
    chk("post rst high", 32'(data_out), 32'd1);
    @(negedge clk);
    chk("post rst done", 32'(done), 32'd1);
    @(negedge clk);

    // random bursts under the pattern monitor
    hist = '0;
    hits = 0;
    wide = 0;
    mon_en = 1'b1;
    sum = 0;
    for (int b = 0; b < 20; b++) begin
      req_valid = 1'b1;
      req_count = 8'($urandom_range(0, 6));
      req_gap   = 4'($urandom_range(0, 3));
      sum += int'(req_count);
      @(posedge clk);
      #1 req_valid = 1'b0;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (done) begin
          ok = 1;
          break;
        end
      end
      chk($sformatf("rnd%0d done seen", b), 32'(ok), 32'd1);
      @(negedge clk);
    end
    @(negedge clk);
    mon_en = 1'b0;
    chk("rnd pulse hits", 32'(hits), 32'(sum));
    chk("rnd wide highs", 32'(wide), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
